aes_pkcs7_padder: RTL and testbench
===================================

// Module: aes_pkcs7_padder
// PURPOSE
//  Upstream stage of the AES-CBC engine's plaintext port. Forwards a 32-bit
//  byte-strobed message stream and appends PKCS#7 padding so the output is an
//  exact multiple of 128-bit blocks (4 words, word 0 first). The output feeds
//  the engine's plaintext stream directly.
// PARAMETERS
//  CNT_WIDTH  16  width of blocks_o output-block counter (wraps)
// PORTS
//  clk_i        in   1   single clock
//  rst_i        in   1   synchronous reset, active-high
//  clear_i      in   1   sync soft clear, same effect as rst_i
//  enable_i     in   1   0: in_ready_o=0, out_valid_o=0, state/counters held
//  in_data_i    in   32  message word, byte k in bits [8k+7:8k]
//  in_strb_i    in   4   byte valid; must be 4'hF except on last beat
//  in_last_i    in   1   final beat of message
//  in_valid_i   in   1   input handshake valid
//  in_ready_o   out  1   input handshake ready
//  out_data_o   out  32  padded output word
//  out_strb_o   out  4   always 4'hF
//  out_last_o   out  1   high on final word of padded message
//  out_valid_o  out  1   output handshake valid
//  out_ready_i  in   1   output handshake ready
//  blocks_o     out  CNT_WIDTH  count of 128-bit blocks fully emitted
//  done_o       out  1   1-cycle pulse after final word handshake
//  err_o        out  1   sticky strobe protocol error
// BEHAVIOUR
//  - Reset/clear: state PASS, word_idx=0, fill_cnt=0, blocks_o=0, done_o=0,
//    err_o=0, out_valid_o=0, out_last_o=0, in_ready_o=0 until enabled.
//  - Handshake: transfer when valid&ready. out_valid_o never depends on
//    out_ready_i; once high, out_data_o/out_last_o stable until handshake.
//    enable_i must not drop while out_valid_o=1 unless clear_i follows.
//  - word_idx: 2-bit, increments on each output handshake, wraps 3->0;
//    wrap increments blocks_o (mod 2^CNT_WIDTH).
//  - PASS: combinational, zero latency: out_valid_o=en&in_valid_i,
//    in_ready_o=en&out_ready_i, out_data_o=in_data_i, out_last_o=0.
//    On last beat: n=popcount(strb) (thermometer 0/1/3/7/F required),
//    P=16-(4*word_idx+n), P in 1..16; bytes with strb=0 replaced by P;
//    F=3-word_idx remaining words; if n=4 and word_idx=3 then P=16, F=4.
//    On last-beat handshake: F>0 -> FILL (latch P, fill_cnt=F);
//    F=0 -> out_last_o=1 on that beat, done_o pulses next cycle, stay PASS.
//  - FILL: in_ready_o=0, out_valid_o=en, out_data_o={4{P}};
//    out_last_o=(fill_cnt==1); each handshake decrements fill_cnt;
//    handshake at fill_cnt==1 -> PASS, done_o pulse next cycle.
//  - Errors (set err_o, sticky until rst_i/clear_i): non-last beat with
//    strb!=4'hF (word forwarded unchanged, counts as full); last beat with
//    non-thermometer strb (treated as 4'hF).
//  - Empty message (single last beat, strb=0): emits 4 words 32'h10101010.
//  - clear_i/rst_i mid-FILL: padding abandoned, next cycle out_valid_o=0.
//  - Simultaneous clear_i and handshake: clear wins, no count update.
// TESTING
//  1 4 full words + last 32'h11223344 strb 4'h3 -> 4 words as-is,
//    32'h0E0E3344, 3x 32'h0E0E0E0E, out_last_o on final; blocks_o=2, done_o.
//  2 4 full words, last on word 3 strb 4'hF -> 4 words as-is then
//    4x 32'h10101010, out_last_o on 8th word; blocks_o=2.
//  3 single beat last strb 4'h0 -> 4x 32'h10101010; blocks_o=1.
//  4 test 1 with out_ready_i 50% random -> no loss/dup, data stable under
//    stall, in_ready_o=0 throughout FILL.
//  5 non-last beat strb 4'h7 -> err_o=1 and stays 1; data forwarded; clear_i
//    -> err_o=0, blocks_o=0.
//  6 rst_i during FILL (fill_cnt=2) -> next cycle out_valid_o=0, PASS,
//    blocks_o=0; new message then padded correctly.

Source files
------------

// File: rtl/aes_pkcs7_padder_if.sv
// Byte-strobed 32-bit valid/ready stream used on both sides of the PKCS#7 padder.
interface aes_pkcs7_padder_if;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        valid;
    logic        ready;

    modport master (output data, strb, last, valid, input ready);
    modport slave  (input data, strb, last, valid, output ready);
endinterface

// File: rtl/aes_pkcs7_padder.sv
// Forwards a byte-strobed message stream and appends PKCS#7 padding up to a
// whole number of 128-bit blocks (4 words, word 0 first).
module aes_pkcs7_padder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    aes_pkcs7_padder_if.slave    in_s,
    aes_pkcs7_padder_if.master   out_m,
    output logic [CNT_WIDTH-1:0] blocks_o,
    output logic                 done_o,
    output logic                 err_o
);
    typedef enum logic {PASS, FILL} state_e;

    state_e      state_q, state_d;
    logic [1:0]  word_idx_q;
    logic [2:0]  fill_cnt_q, fill_cnt_d;
    logic [7:0]  pad_q, pad_d;

    logic        therm;
    logic [3:0]  eff_strb;
    logic [2:0]  n_bytes;
    logic [4:0]  used;
    logic [4:0]  p5;
    logic [7:0]  pad_val;
    logic [2:0]  fwords;
    logic [31:0] pass_data;
    logic        out_valid, out_hs, in_hs, err_cond;

    // A non-thermometer strobe on the last beat is treated as a full word.
    assign therm    = in_s.strb inside {4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    assign eff_strb = therm ? in_s.strb : 4'hF;

    always_comb begin
        case (eff_strb)
            4'h0:    n_bytes = 3'd0;
            4'h1:    n_bytes = 3'd1;
            4'h3:    n_bytes = 3'd2;
            4'h7:    n_bytes = 3'd3;
            default: n_bytes = 3'd4;
        endcase
    end

    assign used    = {1'b0, word_idx_q, 2'b00} + {2'b00, n_bytes};
    assign p5      = 5'd16 - used;
    // used==16 means the message ended exactly on a block: a full pad block follows.
    assign pad_val = (p5 == 5'd0) ? 8'd16 : {3'b000, p5};
    assign fwords  = (word_idx_q == 2'd3 && n_bytes == 3'd4) ? 3'd4
                                                             : 3'd3 - {1'b0, word_idx_q};

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign pass_data[8*b +: 8] = (in_s.last && !eff_strb[b]) ? pad_val
                                                                 : in_s.data[8*b +: 8];
    end

    assign out_valid   = enable_i & ((state_q == FILL) | in_s.valid);
    assign in_s.ready  = enable_i & (state_q == PASS) & out_m.ready;
    assign out_m.valid = out_valid;
    assign out_m.strb  = 4'hF;
    assign out_hs      = out_valid & out_m.ready;
    assign in_hs       = in_s.valid & in_s.ready;
    assign err_cond    = in_s.last ? !therm : (in_s.strb != 4'hF);

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        pad_d      = pad_q;
        out_m.data = pass_data;
        out_m.last = 1'b0;
        case (state_q)
            PASS: begin
                out_m.last = in_s.last & (fwords == 3'd0);
                if (out_hs && in_s.last && fwords != 3'd0) begin
                    state_d    = FILL;
                    fill_cnt_d = fwords;
                    pad_d      = pad_val;
                end
            end
            FILL: begin
                out_m.data = {4{pad_q}};
                out_m.last = (fill_cnt_q == 3'd1);
                if (out_hs) begin
                    fill_cnt_d = fill_cnt_q - 3'd1;
                    if (fill_cnt_q == 3'd1) state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= PASS;
            word_idx_q <= 2'd0;
            fill_cnt_q <= 3'd0;
            pad_q      <= 8'd0;
            blocks_o   <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            pad_q      <= pad_d;
            done_o     <= out_hs & out_m.last;
            if (out_hs) begin
                word_idx_q <= word_idx_q + 2'd1;
                if (word_idx_q == 2'd3) blocks_o <= blocks_o + CNT_WIDTH'(1);
            end
            if (in_hs && err_cond) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_pkcs7_padder.sv
// Directed bench for the PKCS#7 padder: hand-computed output streams per message.
module tb_aes_pkcs7_padder;
    logic        clk_i = 1'b0;
    logic        rst_i, clear_i, enable_i;
    logic [15:0] blocks_o;
    logic        done_o, err_o;

    aes_pkcs7_padder_if in_if();
    aes_pkcs7_padder_if out_if();

    aes_pkcs7_padder #(.CNT_WIDTH(16)) u_dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .enable_i (enable_i),
        .in_s     (in_if),
        .out_m    (out_if),
        .blocks_o (blocks_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    int vecs = 0;
    int errs = 0;

    logic [31:0] in_w [8];
    logic [3:0]  in_s [8];
    logic [31:0] exp_w[8];
    int          nin, nexp, last_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_clear();
        @(negedge clk_i); clear_i = 1'b1;
        @(negedge clk_i); clear_i = 1'b0;
    endtask

    // 4 full words, then last word 11223344 with two valid bytes.
    task automatic load_t1();
        nin = 5; nexp = 8; last_idx = 7;
        for (int i = 0; i < 4; i++) begin
            in_w[i] = 32'hC0DE0000 + 32'(i); in_s[i] = 4'hF; exp_w[i] = in_w[i];
        end
        in_w[4] = 32'h11223344; in_s[4] = 4'h3; exp_w[4] = 32'h0E0E3344;
        for (int i = 5; i < 8; i++) exp_w[i] = 32'h0E0E0E0E;
    endtask

    task automatic run_msg(input bit rnd);
        int          ii, oi, cyc;
        bit          stalled, ihs;
        logic [31:0] hd;
        logic        hl;
        ii = 0; oi = 0; cyc = 0; stalled = 0; hd = '0; hl = 1'b0;
        while (oi < nexp && cyc < 400) begin
            @(negedge clk_i); cyc++;
            if (ii < nin) begin
                in_if.valid = 1'b1; in_if.data = in_w[ii];
                in_if.strb = in_s[ii]; in_if.last = (ii == nin - 1);
            end else begin
                in_if.valid = 1'b0; in_if.last = 1'b0;
            end
            out_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                chk("stall_valid", 32'(out_if.valid), 32'd1);
                chk("stall_data", out_if.data, hd);
                chk("stall_last", 32'(out_if.last), 32'(hl));
            end
            if (ii >= nin) chk("fill_in_ready", 32'(in_if.ready), 32'd0);
            ihs = in_if.valid && in_if.ready;
            if (out_if.valid && out_if.ready) begin
                chk($sformatf("word%0d", oi), out_if.data, exp_w[oi]);
                chk($sformatf("last%0d", oi), 32'(out_if.last), 32'(oi == last_idx));
                chk("strb", 32'(out_if.strb), 32'hF);
                oi++;
            end
            stalled = out_if.valid && !out_if.ready;
            hd = out_if.data; hl = out_if.last;
            if (ihs) ii++;
        end
        if (oi < nexp) chk("timeout_words", 32'(oi), 32'(nexp));
        @(negedge clk_i);
        in_if.valid = 1'b0; in_if.last = 1'b0; out_if.ready = 1'b0;
        #1;
        if (nexp == last_idx + 1) begin
            chk("done_pulse", 32'(done_o), 32'd1);
            @(negedge clk_i); #1;
            chk("done_low", 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b0;
        in_if.valid = 1'b0; in_if.data = '0; in_if.strb = 4'h0; in_if.last = 1'b0;
        out_if.ready = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_blocks", 32'(blocks_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_out_valid", 32'(out_if.valid), 32'd0);
        chk("rst_in_ready", 32'(in_if.ready), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0; in_if.valid = 1'b1; out_if.ready = 1'b1;
        #1;
        chk("dis_in_ready", 32'(in_if.ready), 32'd0);
        chk("dis_out_valid", 32'(out_if.valid), 32'd0);
        @(negedge clk_i);
        in_if.valid = 1'b0; enable_i = 1'b1;

        // 1: short last word, three pad words follow
        load_t1();
        run_msg(1'b0);
        chk("t1_blocks", 32'(blocks_o), 32'd2);
        chk("t1_err", 32'(err_o), 32'd0);

        // 2: message ends on a block boundary, full pad block appended
        do_clear();
        nin = 4; nexp = 8; last_idx = 7;
        for (int i = 0; i < 4; i++) begin
            in_w[i] = 32'hA5A50000 + 32'(i); in_s[i] = 4'hF; exp_w[i] = in_w[i];
            exp_w[4 + i] = 32'h10101010;
        end
        run_msg(1'b0);
        chk("t2_blocks", 32'(blocks_o), 32'd2);

        // 3: empty message
        do_clear();
        nin = 1; nexp = 4; last_idx = 3;
        in_w[0] = 32'hDEADBEEF; in_s[0] = 4'h0;
        for (int i = 0; i < 4; i++) exp_w[i] = 32'h10101010;
        run_msg(1'b0);
        chk("t3_blocks", 32'(blocks_o), 32'd1);

        // 4: test 1 with random output backpressure
        do_clear();
        load_t1();
        run_msg(1'b1);
        chk("t4_blocks", 32'(blocks_o), 32'd2);

        // 5: bad strobe on a non-last beat
        do_clear();
        nin = 4; nexp = 8; last_idx = 7;
        for (int i = 0; i < 4; i++) begin
            in_w[i] = 32'h5A000000 + 32'(i); in_s[i] = 4'hF; exp_w[i] = in_w[i];
            exp_w[4 + i] = 32'h10101010;
        end
        in_s[0] = 4'h7;
        run_msg(1'b0);
        chk("t5_err", 32'(err_o), 32'd1);
        repeat (3) @(negedge clk_i);
        #1;
        chk("t5_err_sticky", 32'(err_o), 32'd1);
        do_clear();
        #1;
        chk("t5_clr_err", 32'(err_o), 32'd0);
        chk("t5_clr_blocks", 32'(blocks_o), 32'd0);

        // 6: reset while two pad words remain
        load_t1();
        nexp = 6;
        run_msg(1'b0);
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("t6_out_valid", 32'(out_if.valid), 32'd0);
        chk("t6_blocks", 32'(blocks_o), 32'd0);
        @(negedge clk_i); rst_i = 1'b0;
        nin = 1; nexp = 4; last_idx = 3;
        in_w[0] = 32'h00000000; in_s[0] = 4'h0;
        for (int i = 0; i < 4; i++) exp_w[i] = 32'h10101010;
        run_msg(1'b0);
        chk("t6_after_blocks", 32'(blocks_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
